// File: rtl/uart_block_codec.sv
// uart_block_codec: bridges the UART byte stream and the 128-bit AES block stream.
//
// Gather half: packs BLK_BYTES received bytes (first byte ends up most significant) into
// one block. A programmable inter-byte timeout drops a stale partial block so that an
// aborted host transfer cannot shift the framing of later blocks.
// Scatter half: latches a result block and sends it out most-significant byte first.
//
// Ports:
//   Clk, Rst           clock, synchronous active-high reset
//   En                 global enable; low forces all tready/tvalid low and holds all state
//   s_byte_*           UART RX byte stream in (AXI4-Stream)
//   m_blk_*            gathered block out to the AES core
//   s_blk_*            AES result block in
//   m_byte_*           UART TX byte stream out
//   timeout            idle-cycle limit between bytes of a partial block, 0 = disabled
//   gather_level       bytes held in the partial block
//   scatter_busy       scatter is holding a block
//   timeout_err        one-cycle pulse when a partial block is discarded
module uart_block_codec #(
  parameter int unsigned BLK_BYTES = 16,
  parameter int unsigned TO_W      = 24
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   En,
  input  logic [7:0]             s_byte_tdata,
  input  logic                   s_byte_tvalid,
  output logic                   s_byte_tready,
  output logic [8*BLK_BYTES-1:0] m_blk_tdata,
  output logic                   m_blk_tvalid,
  input  logic                   m_blk_tready,
  input  logic [8*BLK_BYTES-1:0] s_blk_tdata,
  input  logic                   s_blk_tvalid,
  output logic                   s_blk_tready,
  output logic [7:0]             m_byte_tdata,
  output logic                   m_byte_tvalid,
  input  logic                   m_byte_tready,
  input  logic [TO_W-1:0]        timeout,
  output logic [4:0]             gather_level,
  output logic                   scatter_busy,
  output logic                   timeout_err
);

  localparam int unsigned BW   = 8 * BLK_BYTES;
  localparam int unsigned IdxW = $clog2(BLK_BYTES);
  localparam logic [4:0]      LastLvl = 5'(BLK_BYTES - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLK_BYTES - 1);

  typedef enum logic {StFill, StFull} gather_state_e;
  typedef enum logic {StIdle, StSend} scatter_state_e;

  gather_state_e   g_state;
  logic [BW-1:0]   g_data;
  logic [4:0]      g_level;
  logic [TO_W-1:0] idle_cnt;
  logic            to_err;

  scatter_state_e  s_state;
  logic [BW-1:0]   s_data;
  logic [IdxW-1:0] s_idx;

  logic byte_hs;
  logic to_hit;

  // Readies/valids are held low while reset is asserted so nothing handshakes then.
  assign s_byte_tready = En & ~Rst & (g_state == StFill);
  assign m_blk_tvalid  = En & ~Rst & (g_state == StFull);
  assign s_blk_tready  = En & ~Rst & (s_state == StIdle);
  assign m_byte_tvalid = En & ~Rst & (s_state == StSend);

  assign m_blk_tdata  = g_data;
  assign m_byte_tdata = s_data[BW-1 -: 8];
  assign gather_level = g_level;
  assign scatter_busy = (s_state == StSend);
  assign timeout_err  = to_err;

  assign byte_hs = s_byte_tready & s_byte_tvalid;

  // This idle cycle would be the timeout-th one since the last byte; extra bit avoids wrap.
  assign to_hit = (timeout != '0) &&
                  (({1'b0, idle_cnt} + {{TO_W{1'b0}}, 1'b1}) == {1'b0, timeout});

  // Gather FSM
  always_ff @(posedge Clk) begin
    if (Rst) begin
      g_state  <= StFill;
      g_data   <= '0;
      g_level  <= '0;
      idle_cnt <= '0;
      to_err   <= 1'b0;
    end else begin
      to_err <= 1'b0;
      if (En) begin
        unique case (g_state)
          StFill: begin
            if (byte_hs) begin
              // A byte on the limit cycle wins over the timeout.
              g_data   <= {g_data[BW-9:0], s_byte_tdata};
              g_level  <= g_level + 5'd1;
              idle_cnt <= '0;
              if (g_level == LastLvl) g_state <= StFull;
            end else if (g_level == '0) begin
              idle_cnt <= '0;
            end else if (to_hit) begin
              g_level  <= '0;
              idle_cnt <= '0;
              to_err   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          StFull: begin
            if (m_blk_tready) begin
              g_level <= '0;
              g_state <= StFill;
            end
          end
          default: g_state <= StFill;
        endcase
      end
    end
  end

  // Scatter FSM; the block shifts left so the current byte is always on top.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s_state <= StIdle;
      s_data  <= '0;
      s_idx   <= '0;
    end else if (En) begin
      unique case (s_state)
        StIdle: begin
          if (s_blk_tvalid) begin
            s_data  <= s_blk_tdata;
            s_idx   <= '0;
            s_state <= StSend;
          end
        end
        StSend: begin
          if (m_byte_tready) begin
            s_data <= {s_data[BW-9:0], 8'h00};
            s_idx  <= s_idx + 1'b1;
            if (s_idx == LastIdx) s_state <= StIdle;
          end
        end
        default: s_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/uart_block_codec.md
# uart_block_codec

Converts between the UART byte stream and the 128-bit AES block stream in the aes_uart datapath. The gather half takes received bytes from the UART receive AXI4-Stream and packs 16 of them into one block for the AES core. The scatter half takes AES result blocks and serialises them, most-significant byte first, into the UART transmit AXI4-Stream. A programmable inter-byte timeout discards stale partial blocks, so a host that aborts mid-block cannot desynchronise framing.

## Interface
- BLK_BYTES, 16, bytes per block; block width = 8*BLK_BYTES
- TO_W, 24, width of the timeout counter and the `timeout` port
---
- Clk  in  1  clock; one clock domain
- Rst  in  1  synchronous, active-high reset
- En  in  1  global enable; when low, all tready/tvalid outputs are forced low and all state holds
- s_byte_tdata  in  8  received byte from the UART RX stream
- s_byte_tvalid  in  1  byte valid
- s_byte_tready  out  1  gather can accept a byte
- m_blk_tdata  out  8*BLK_BYTES  gathered block
- m_blk_tvalid  out  1  block valid
- m_blk_tready  in  1  AES core accepts the block
- s_blk_tdata  in  8*BLK_BYTES  result block to transmit
- s_blk_tvalid  in  1  result valid
- s_blk_tready  out  1  scatter can accept a block
- m_byte_tdata  out  8  byte to the UART TX stream
- m_byte_tvalid  out  1  byte valid
- m_byte_tready  in  1  TX accepts the byte
- timeout  in  TO_W  idle-cycle limit between bytes of a partial block; 0 disables the timeout
- gather_level  out  5  bytes currently held in the partial block (0..16)
- scatter_busy  out  1  scatter is holding a block
- timeout_err  out  1  one-cycle pulse when a partial block is discarded

## Operation
- A handshake occurs on any cycle where tvalid=1, tready=1 and En=1.
- Gather states: FILL, FULL.
  - FILL: s_byte_tready=1. Each accepted byte shifts into the shift register. The first byte of a block ends in bits [127:120] and the 16th byte ends in [7:0].
  - Level increments on each accepted byte. The 16th byte moves the state to FULL.
  - FULL: m_blk_tvalid=1 and s_byte_tready=0. On m_blk handshake: level goes to 0 and the state returns to FILL.
  - m_blk_tdata is stable while m_blk_tvalid=1.
- Timeout applies only in FILL with 0<level<16.
  - The idle counter increments on each cycle with En=1 and no byte handshake. It clears on a byte handshake or when level=0.
  - When the counter equals `timeout` and timeout≠0: level goes to 0, the counter clears, and timeout_err pulses for 1 cycle.
  - If a byte handshake occurs in the same cycle that the counter would hit the limit, the byte wins: it is accepted and no timeout fires.
  - The timeout never fires in FULL.
- Scatter states: IDLE, SEND.
  - IDLE: s_blk_tready=1. On handshake: latch the block, clear the byte index, go to SEND.
  - SEND: m_byte_tvalid=1. m_byte_tdata = block byte[index], where index 0 is bits [127:120].
  - Index increments on each m_byte handshake. The handshake on index 15 returns the state to IDLE.
  - m_byte_tdata is stable while m_byte_tvalid=1 and no handshake has occurred.
- Gather and scatter are fully independent and may operate on the same cycle.
- En low: no handshakes occur, no counters advance (including the timeout counter), and all state is retained. Normal operation resumes when En returns high.

## Timing
- Reset values:
  - s_byte_tready=0 during reset, then 1 on the first cycle after reset.
  - s_blk_tready: same as s_byte_tready.
  - m_blk_tvalid=0, m_byte_tvalid=0, m_blk_tdata=0, m_byte_tdata=0.
  - gather_level=0, scatter_busy=0, timeout_err=0.
  - The gather starts in FILL and the scatter in IDLE.
- Rst asserted mid-operation discards any partial or pending block in both halves; nothing is emitted afterwards.
- Gather latency: m_blk_tvalid rises 1 cycle after the 16th byte handshake.
- Minimum gather period: 16 byte cycles plus 1 block handshake cycle. s_byte_tready returns high the cycle after the m_blk handshake.
- Scatter latency: m_byte_tvalid rises 1 cycle after the s_blk handshake.
  - With m_byte_tready held high, 16 bytes go out on 16 consecutive cycles.
  - s_blk_tready returns high the cycle after the last byte handshake, giving a period of 17 cycles per block.
- gather_level and scatter_busy are registered and update on the cycle after the causing handshake.
- timeout_err asserts on the cycle after the counter reaches `timeout`.

## Test plan
- Gather: send bytes 0x00..0x0F with m_blk_tready=1 -> m_blk_tdata=0x000102030405060708090A0B0C0D0E0F, m_blk_tvalid high for exactly 1 cycle, gather_level returns to 0.
- Gather backpressure: 16 bytes sent with m_blk_tready=0 for 20 cycles -> s_byte_tready=0 and m_blk_tdata stable throughout; the 17th byte is accepted only after the block handshake.
- Scatter: s_blk=0xA0A1…AF with random m_byte_tready -> bytes 0xA0,0xA1,…,0xAF in order, none dropped or repeated; s_blk_tready=0 until 0xAF is accepted.
- Timeout: timeout=100, send 5 bytes, then idle -> timeout_err pulses exactly 100 idle cycles after the 5th byte, level=0. The next 16 bytes form a clean block.
- Timeout boundary: a byte arrives on the exact limit cycle -> no timeout_err, level=6. With timeout=0, an idle gap of 10^6 cycles causes no discard.
- Concurrency and reset: gather and scatter run simultaneously, with Rst pulsed mid-block -> all valids drop, level=0, and no stale bytes or blocks appear after reset.
